// File: rtl/mult8x8_seq_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier and its nibble core.
package mult_pkg;

    localparam int MULT_W     = 8;
    localparam int NIB_W      = 4;
    localparam int PROD_W     = 16;
    localparam int MULT_STEPS = 4;
    localparam int CNT_W      = $clog2(MULT_STEPS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Left shift applied to each nibble partial product: lo*lo, lo*hi, hi*lo, hi*hi.
    function automatic logic [3:0] step_shift(input logic [CNT_W-1:0] step);
        case (step)
            2'd0:    return 4'd0;
            2'd1:    return 4'd4;
            2'd2:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/mult8x8_seq_if.sv
// Operand/result bundle between the register-read stage and the multiplier.
interface mult8x8_seq_if;
    import mult_pkg::*;

    logic              start;
    logic [MULT_W-1:0] a;
    logic [MULT_W-1:0] b;
    logic              busy;
    logic              done;
    logic [PROD_W-1:0] p;

    modport master (output start, a, b, input  busy, done, p);
    modport slave  (input  start, a, b, output busy, done, p);
endinterface

// File: rtl/mult8x8_seq_mult4x4.sv
// Combinational unsigned 4x4 nibble multiplier; zero latency, no flow control.
module mult4x4
    import mult_pkg::*;
(
    input  logic [NIB_W-1:0]   i_a,
    input  logic [NIB_W-1:0]   i_b,
    output logic [2*NIB_W-1:0] o_p
);
    assign o_p = (2*NIB_W)'(i_a) * (2*NIB_W)'(i_b);
endmodule

// File: rtl/mult8x8_seq.sv
// Sequential 8x8 multiplier on one mult4x4: start->done in 5 cycles, start ignored while busy.
// Define MULT_SIGNED_EN for two's complement operands (sign-magnitude around the unsigned core).
module mult8x8_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mult8x8_seq_if.slave  s_bus
);
    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [PROD_W-1:0]  r_acc, r_p;

    logic [NIB_W-1:0]   w_nib_a, w_nib_b;
    logic [2*NIB_W-1:0] w_nib_p;
    logic [PROD_W-1:0]  w_pp, w_sum, w_result;
    logic [WIDTH-1:0]   w_opa, w_opb;
    logic               w_accept, w_last;

`ifdef MULT_SIGNED_EN
    logic r_neg;

    assign w_opa    = s_bus.a[WIDTH-1] ? WIDTH'(0) - s_bus.a : s_bus.a;
    assign w_opb    = s_bus.b[WIDTH-1] ? WIDTH'(0) - s_bus.b : s_bus.b;
    assign w_result = r_neg ? PROD_W'(0) - w_sum : w_sum;
`else
    assign w_opa    = s_bus.a;
    assign w_opb    = s_bus.b;
    assign w_result = w_sum;
`endif

    assign w_nib_a = r_cnt[1] ? r_a[WIDTH-1:NIB_W] : r_a[NIB_W-1:0];
    assign w_nib_b = r_cnt[0] ? r_b[WIDTH-1:NIB_W] : r_b[NIB_W-1:0];

    mult4x4 u_mult4x4 (
        .i_a (w_nib_a),
        .i_b (w_nib_b),
        .o_p (w_nib_p)
    );

    assign w_pp  = PROD_W'(w_nib_p) << step_shift(r_cnt);
    assign w_sum = r_acc + w_pp;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s_bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_MUL;
                end
            end
            ST_MUL: begin
                if (r_cnt == CNT_W'(MULT_STEPS - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
`ifdef MULT_SIGNED_EN
            r_neg   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a   <= w_opa;
                r_b   <= w_opb;
                r_cnt <= '0;
                r_acc <= '0;
`ifdef MULT_SIGNED_EN
                r_neg <= s_bus.a[WIDTH-1] ^ s_bus.b[WIDTH-1];
`endif
            end else if (r_state == ST_MUL) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Result is loaded on the edge into DONE so it is visible with done. A reset that
    // aborts an operation keeps the previous result; a reset while idle clears it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            if (r_state == ST_IDLE) r_p <= '0;
        end else if (w_last) begin
            r_p <= w_result;
        end
    end

    assign s_bus.busy = (r_state != ST_IDLE);
    assign s_bus.done = (r_state == ST_DONE);
    assign s_bus.p    = r_p;

endmodule

// File: tb/tb_mult8x8_seq.sv
// Directed bench for mult8x8_seq: vector table plus ignored-start and mid-operation reset sequences.
module tb_mult8x8_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] last_p;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_p;
    } vec_t;

    vec_t vec [8];

    always #5 clk = ~clk;

    mult8x8_seq_if bus ();

    mult8x8_seq #(.WIDTH(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .s_bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full transaction from idle; checks busy/done each cycle, p hold, latency and result.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.a     = ~a;
                bus.b     = 8'($urandom);
            end
            check($sformatf("busy_k%0d", k), 32'(bus.busy), 32'd1);
            check($sformatf("done_k%0d", k), 32'(bus.done), (k == 5) ? 32'd1 : 32'd0);
            if (k < 5) check($sformatf("p_hold_k%0d", k), 32'(bus.p), 32'(last_p));
            else       check($sformatf("p_%0h_x_%0h", a, b), 32'(bus.p), 32'(exp_p));
        end
        @(negedge clk);
        check("busy_after", 32'(bus.busy), 32'd0);
        check("done_after", 32'(bus.done), 32'd0);
        check("p_kept", 32'(bus.p), 32'(exp_p));
        last_p = exp_p;
    endtask

    initial begin
        vec[0] = '{8'd13, 8'd11, 16'h008F};
        vec[1] = '{8'h00, 8'hAB, 16'h0000};
        vec[2] = '{8'h12, 8'h34, 16'h03A8};
        vec[3] = '{8'h80, 8'h80, 16'h4000};
`ifdef MULT_SIGNED_EN
        vec[4] = '{8'hFF, 8'hFF, 16'h0001};
        vec[5] = '{8'hFF, 8'h02, 16'hFFFE};
        vec[6] = '{8'h80, 8'h01, 16'hFF80};
        vec[7] = '{8'hF0, 8'h0F, 16'hFF10};
`else
        vec[4] = '{8'hFF, 8'hFF, 16'hFE01};
        vec[5] = '{8'hFF, 8'h02, 16'h01FE};
        vec[6] = '{8'h80, 8'h01, 16'h0080};
        vec[7] = '{8'hF0, 8'h0F, 16'h0E10};
`endif

        // Reset with a coincident start that must not be taken.
        bus.start = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'h66;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_p", 32'(bus.p), 32'h0000);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_start_ignored", 32'(bus.busy), 32'd0);
        last_p = 16'h0000;

        for (int i = 0; i < 8; i++) run_op(vec[i].a, vec[i].b, vec[i].exp_p);

        // Starts pulsed during MUL and during DONE are ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd3;
        bus.b     = 8'd5;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus.start = (k == 2 || k == 5);
            bus.a     = 8'd7;
            bus.b     = 8'd7;
            if (k == 5) begin
                check("ign_done", 32'(bus.done), 32'd1);
                check("ign_p", 32'(bus.p), 32'h000F);
            end
            if (k >= 6) begin
                check($sformatf("ign_busy_k%0d", k), 32'(bus.busy), 32'd0);
                check($sformatf("ign_p_k%0d", k), 32'(bus.p), 32'h000F);
            end
        end
        bus.start = 1'b0;
        last_p    = 16'h000F;

        // Reset in the third MUL cycle aborts the operation and keeps the prior result.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd2;
        bus.b     = 8'd9;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_p", 32'(bus.p), 32'h000F);
        begin
            int seen_done = 0;
            int seen_busy = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (bus.done) seen_done++;
                if (bus.busy) seen_busy++;
            end
            check("abort_no_done", 32'(seen_done), 32'd0);
            check("abort_stays_idle", 32'(seen_busy), 32'd0);
        end
        check("abort_p_held", 32'(bus.p), 32'h000F);

        run_op(8'h21, 8'h04, 16'h0084);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult8x8_seq.md
# mult8x8_seq

Sequential 8x8 multiplier for the CPU datapath, built around one instance of the existing combinational `mult4x4` nibble multiplier. It accepts two 8-bit operands on a start pulse and forms the four nibble partial products over four cycles, one per cycle. It shift-accumulates them into a 16-bit product and signals completion with a one-cycle `done` pulse. It sits between the operand register file read stage and the ALU result mux, trading latency for area against a full 8x8 array.

## Interface
- `WIDTH`, 8: operand width; fixed at 8; must be twice the sub-multiplier width (4).
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  **synchronous, active-high** reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  8  multiplicand; sampled with `start`.
- `b`  in  8  multiplier; sampled with `start`.
- `busy`  out  1  high from the cycle after acceptance through the DONE cycle inclusive.
- `done`  out  1  one-cycle pulse; `p` is valid from this cycle on.
- `p`  out  16  product register; holds its value until the next `done`.

## Operation
- FSM states: IDLE, MUL, DONE.
  - IDLE: if `start`, latch `a` and `b`, clear the accumulator, set step counter `cnt`=0, go to MUL.
  - MUL: one partial product per cycle, added into the 16-bit accumulator. When `cnt`==3, accumulate and go to DONE; otherwise increment `cnt`.
  - DONE: load `p` from the final accumulator value, assert `done`, return to IDLE.
- Step schedule (a_lo=a[3:0], a_hi=a[7:4], same for b):
  - cnt0: a_lo*b_lo << 0
  - cnt1: a_lo*b_hi << 4
  - cnt2: a_hi*b_lo << 4
  - cnt3: a_hi*b_hi << 8
- Arithmetic: unsigned, 16-bit accumulator, no carry-out. The maximum is 255*255=65025, so no overflow is possible.
- `start` while `busy` (MUL or DONE) is ignored: no re-latch, no queuing.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- `p` updates only in DONE; a mid-operation read returns the previous result.

## Timing
- `start` sampled at edge T (IDLE) → MUL during T+1..T+4 → DONE at T+5.
  - `done`=1 and new `p` visible in cycle T+5.
  - `busy`=1 in cycles T+1..T+5.
- Next `start` is accepted at edge T+6 at the earliest. Throughput: one product per 6 cycles.
- Reset values: `busy`=0, `done`=0, `p`=16'h0000, state=IDLE, `cnt`=0, accumulator=0.
- Reset mid-operation: immediate return to IDLE, result discarded, no `done`. `start` coincident with `rst` is ignored.

## Configuration
- `MULT_SIGNED_EN` defined: `a` and `b` are two's complement.
  - On acceptance, the magnitudes |a| and |b| are latched (|−128| = 128 fits in 8 bits unsigned), and the sign is latched as a[7]^b[7].
  - The core runs unsigned. In DONE, `p` = sign ? −acc : acc (16-bit two's complement).
  - Latency is unchanged.
- Not defined: pure unsigned operation. No sign logic and no negation adder are synthesized.

## Structure
- Shared package `mult_pkg`:
  - FSM state encoding (IDLE/MUL/DONE).
  - `MULT_W`=8, `NIB_W`=4, `PROD_W`=16, `MULT_STEPS`=4.
  - The per-step shift constants (0, 4, 4, 8).
- One sub-module: `mult4x4`, instantiated once. Its operand nibbles are selected by `cnt`: a_hi when `cnt`[1]=1, b_hi when `cnt`[0]=1, the low nibbles otherwise.
- The accumulator, counter and FSM are local; no further hierarchy.

## Test plan
- a=13, b=11, start at T → `done` at T+5, `p`=0x008F; `busy` high T+1..T+5, low at T+6.
- a=0xFF, b=0xFF → `p`=0xFE01; a=0, b=0xAB → `p`=0x0000 with a full 5-cycle latency.
- Operation running on a=3, b=5; `start` with a=7, b=7 pulsed at T+2 and at T+5 → ignored; `p`=0x000F.
- `rst` asserted at T+3 → next cycle `busy`=0, `done` never pulses, `p` holds its prior value 0x000F. A fresh start then completes normally.
- With `MULT_SIGNED_EN`:
  - a=0xFF, b=0x02 → `p`=0xFFFE.
  - a=0x80, b=0x80 → `p`=0x4000.
  - a=0x80, b=0x01 → `p`=0xFF80.
- Without `MULT_SIGNED_EN`: a=0xFF, b=0x02 → `p`=0x01FE.
